bcd_stopwatch: RTL and testbench
================================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL expose parameter: SYNC_STAGES, 2, synchroniser flops per key input.
REQ-002 SHALL expose parameter: DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level (10 ms at 50 MHz).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: Clock  in  1  single system clock (50 MHz board oscillator), rising edge.
REQ-005 Port: Reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: tick  in  1  one-cycle enable pulse, 1 Hz, from the upstream timer terminal count.
REQ-007 Port: key_start_n  in  1  raw asynchronous pushbutton, active-low, start/stop toggle.
REQ-008 Port: key_clear_n  in  1  raw asynchronous pushbutton, active-low, clear.
REQ-009 Port: sec_ones  out  4  BCD 0-9.
REQ-010 Port: sec_tens  out  4  BCD 0-5.
REQ-011 Port: min_ones  out  4  BCD 0-9.
REQ-012 Port: min_tens  out  4  BCD 0-5.
REQ-013 Port: running  out  1  high while FSM is in RUN.
REQ-014 Port: rollover  out  1  one-cycle pulse on the 59:59 -> 00:00 wrap.

Function
REQ-015 Each key SHALL pass through SYNC_STAGES flops, then a debouncer that changes its accepted level only after the synchronised input holds the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A press event SHALL be a one-cycle pulse on an accepted-level 1->0 transition; a held key SHALL produce exactly one event, and release SHALL produce none.
REQ-017 Press-event latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the first edge that samples the key low, for a clean key.
REQ-018 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-019 FSM transitions: IDLE--start-->RUN; RUN--start-->PAUSE; PAUSE--start-->RUN; any state--clear-->IDLE.
REQ-020 Clear SHALL zero all four digits on the same edge; clear wins over a simultaneous start or tick.
REQ-021 A tick SHALL increment the count only when the current state is RUN; a tick in IDLE or PAUSE SHALL be ignored.
REQ-022 When a RUN-state tick and a start event coincide, the tick SHALL be counted and the state SHALL become PAUSE on the same edge.
REQ-023 Digits SHALL update on the edge at which tick is sampled high; there is no further latency.
REQ-024 Carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 wraps.
REQ-025 On a tick at 59:59, digits SHALL become 00:00, and rollover SHALL be high for exactly the next cycle; the FSM SHALL stay in RUN.
REQ-026 No digit SHALL ever hold a value above its stated maximum.
REQ-027 running SHALL be a registered decode of the state; it is high exactly while the state is RUN.

Reset
REQ-028 While Reset_n is low, all digits SHALL be 0, the state SHALL be IDLE, and running and rollover SHALL be 0.
REQ-029 Reset SHALL set synchroniser and debounced levels to 1 (released) and debounce counters to 0, so that no press event follows reset release with keys up.
REQ-030 A reset asserted mid-count SHALL take effect immediately (asynchronously) and lose the count.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state type (IDLE, RUN, PAUSE) and the constants DIGIT_MAX=9 and TENS_MAX=5.
REQ-032 Sub-module key_conditioner (synchroniser, debounce counter and falling-edge pulse) SHALL be instantiated once per key.
REQ-033 Digit outputs SHALL drive the existing hex7seg decoder unchanged, one instance per digit, outside this block.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-034 Press start (key_start_n held low), then 10 ticks -> display 00:10, running=1.
REQ-035 From 00:05 in RUN: press start, apply 3 ticks -> display stays 00:05, running=0; press start again, apply 1 tick -> 00:06.
REQ-036 Apply 3599 ticks in RUN -> 59:59; one more tick -> 00:00, rollover high for 1 cycle, running=1.
REQ-037 At 00:09 in RUN, clear event and tick in the same cycle -> 00:00, state IDLE, running=0.
REQ-038 Toggle key_start_n every 2 cycles for 20 cycles, then hold low -> exactly one press event, at the REQ-017 latency counted from the final low.
REQ-039 Assert Reset_n low asynchronously at 12:34 in RUN -> all outputs 0 before the next edge; after release, no spurious start event occurs.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type, digit limits and BCD step helper
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Next BCD value for a digit with the given maximum; anything at or above
  // the maximum wraps to zero so a digit can never leave its legal range.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - pushbutton synchroniser, debouncer and press pulse
module key_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   level_d1;
  logic                   level_d2;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the raw key through the synchroniser chain; reset reads as released.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= key_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Two delay flops then a registered falling-edge detect, so the press pulse
  // lands SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the key is first sampled low.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      level_d1 <= 1'b1;
      level_d2 <= 1'b1;
      press    <= 1'b0;
    end else begin
      level_d1 <= level_q;
      level_d2 <= level_d1;
      press    <= level_d2 & ~level_d1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - mm:ss BCD stopwatch with start/stop and clear keys
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  logic   start_evt;
  logic   clear_evt;
  state_t state_q;
  state_t state_d;
  logic   count_en;
  logic   sec_ones_max;
  logic   sec_tens_max;
  logic   min_ones_max;
  logic   min_tens_max;

  key_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_start (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .key_n  (key_start_n),
    .press  (start_evt)
  );

  key_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_clear (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .key_n  (key_clear_n),
    .press  (clear_evt)
  );

  // Ticks are judged against the current state, so a start that coincides
  // with a RUN tick still lets that tick count before pausing.
  assign count_en     = tick && (state_q == RUN);
  assign sec_ones_max = (sec_ones >= DIGIT_MAX);
  assign sec_tens_max = (sec_tens >= TENS_MAX);
  assign min_ones_max = (min_ones >= DIGIT_MAX);
  assign min_tens_max = (min_tens >= TENS_MAX);

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear beats start from any state; start toggles run/pause.
  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = IDLE;
    end else if (start_evt) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // running mirrors the state register exactly by decoding the next state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      running <= 1'b0;
    end else begin
      running <= (state_d == RUN);
    end
  end

  // Digit chain: each digit steps only when every lower digit is at its maximum.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (clear_evt) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (count_en) begin
      sec_ones <= bcd_next(sec_ones, DIGIT_MAX);
      if (sec_ones_max) begin
        sec_tens <= bcd_next(sec_tens, TENS_MAX);
        if (sec_tens_max) begin
          min_ones <= bcd_next(min_ones, DIGIT_MAX);
          if (min_ones_max) begin
            min_tens <= bcd_next(min_tens, TENS_MAX);
          end
        end
      end
    end
  end

  // One-cycle pulse after the 59:59 -> 00:00 wrap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rollover <= 1'b0;
    end else begin
      rollover <= !clear_evt && count_en && sec_ones_max && sec_tens_max
                  && min_ones_max && min_tens_max;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - self-checking bench for bcd_stopwatch
module tb_bcd_stopwatch;

  localparam int S = 2;
  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       rollover;

  int vectors = 0;
  int miscompares = 0;

  bcd_stopwatch #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .tick       (tick),
    .key_start_n(key_start_n),
    .key_clear_n(key_clear_n),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: elapsed seconds as one integer, mode as 0=idle 1=run 2=pause.
  int m_count;
  int m_mode;
  bit m_roll;
  bit hs[$];
  bit hc[$];
  bit lvl_s, lvl_c;
  bit f1s, f2s, evs;
  bit f1c, f2c, evc;

  function automatic void model_reset();
    m_count = 0;
    m_mode  = 0;
    m_roll  = 0;
    hs.delete();
    hc.delete();
    for (int i = 0; i < S + D; i++) begin
      hs.push_back(1'b1);
      hc.push_back(1'b1);
    end
    lvl_s = 1; lvl_c = 1;
    f1s = 0; f2s = 0; evs = 0;
    f1c = 0; f2c = 0; evc = 0;
  endfunction

  // True when the last D synchronised samples all disagree with the accepted level.
  function automatic bit window_flips(bit q[$], bit lvl);
    int top = q.size() - 1 - S;
    for (int i = 0; i < D; i++) begin
      if (q[top - i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(bit t, bit ks, bit kc);
    bit fell_s, fell_c;
    if (evc) begin
      m_count = 0;
      m_mode  = 0;
      m_roll  = 0;
    end else begin
      m_roll = (m_mode == 1) && t && (m_count == 3599);
      if (m_mode == 1 && t) m_count = (m_count + 1) % 3600;
      if (evs) m_mode = (m_mode == 1) ? 2 : 1;
    end
    hs.push_back(ks);
    hc.push_back(kc);
    fell_s = 0; fell_c = 0;
    if (window_flips(hs, lvl_s)) begin
      lvl_s = ~lvl_s;
      fell_s = (lvl_s == 0);
    end
    if (window_flips(hc, lvl_c)) begin
      lvl_c = ~lvl_c;
      fell_c = (lvl_c == 0);
    end
    while (hs.size() > S + D + 1) void'(hs.pop_front());
    while (hc.size() > S + D + 1) void'(hc.pop_front());
    evs = f2s; f2s = f1s; f1s = fell_s;
    evc = f2c; f2c = f1c; f1c = fell_c;
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(posedge Clock) begin
    logic [17:0] exp_v;
    logic [17:0] act_v;
    int secs, mins;
    #1;
    secs = m_count % 60;
    mins = m_count / 60;
    exp_v = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
             (m_mode == 1), m_roll};
    act_v = {min_tens, min_ones, sec_tens, sec_ones, running, rollover};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_compare at %0t: got %h%h:%h%h run=%b roll=%b, required %h%h:%h%h run=%b roll=%b",
               $time, act_v[17:14], act_v[13:10], act_v[9:6], act_v[5:2], act_v[1], act_v[0],
               exp_v[17:14], exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end
  end

  task automatic step(input bit t, input bit ks, input bit kc);
    tick = t;
    key_start_n = ks;
    key_clear_n = kc;
    @(posedge Clock);
    if (!Reset_n) model_reset();
    else model_step(t, ks, kc);
    #1;
  endtask

  task automatic press_key(input bit is_start, input int hold);
    for (int i = 0; i < hold; i++) step(0, !is_start, is_start);
    for (int i = 0; i < 12; i++) step(0, 1, 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1);
  endtask

  initial begin
    int rise_at;
    int rises;
    bit prev_run;
    int ps, pc;

    model_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    check_lit("reset_sec_ones", sec_ones, 0);
    check_lit("reset_running", running, 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1, 1);
    check_lit("post_reset_running", running, 0);

    // Start then ten ticks.
    press_key(1, 10);
    ticks(10);
    check_lit("req034_model_count", m_count, 10);
    check_lit("req034_sec_tens", sec_tens, 1);
    check_lit("req034_sec_ones", sec_ones, 0);
    check_lit("req034_running", running, 1);

    // Pause holds the count, resume continues.
    press_key(0, 10);
    press_key(1, 10);
    ticks(5);
    press_key(1, 10);
    ticks(3);
    check_lit("req035_paused_sec_ones", sec_ones, 5);
    check_lit("req035_paused_running", running, 0);
    check_lit("req035_model_count", m_count, 5);
    press_key(1, 10);
    ticks(1);
    check_lit("req035_resumed_sec_ones", sec_ones, 6);

    // Full hour and wrap.
    press_key(0, 10);
    press_key(1, 10);
    ticks(3599);
    check_lit("req036_min_tens", min_tens, 5);
    check_lit("req036_min_ones", min_ones, 9);
    check_lit("req036_sec_tens", sec_tens, 5);
    check_lit("req036_sec_ones", sec_ones, 9);
    ticks(1);
    check_lit("req036_wrap_digits", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    check_lit("req036_rollover_hi", rollover, 1);
    check_lit("req036_running", running, 1);
    step(0, 1, 1);
    check_lit("req036_rollover_lo", rollover, 0);

    // Clear event lands on the same edge as a tick at 00:09.
    press_key(0, 10);
    press_key(1, 10);
    ticks(9);
    check_lit("req037_pre_count", m_count, 9);
    for (int i = 0; i < 16; i++) step(i == S + D + 2, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1);
    check_lit("req037_sec_ones", sec_ones, 0);
    check_lit("req037_running", running, 0);
    check_lit("req037_model_mode", m_mode, 0);

    // Bouncing start key, then a clean hold.
    rise_at = -1;
    rises = 0;
    prev_run = running;
    for (int c = 0; c < 60; c++) begin
      step(0, (c < 20) ? (((c / 2) % 2) != 0) : 1'b0, 1);
      if (running && !prev_run) begin
        rises++;
        if (rise_at < 0) rise_at = c;
      end
      prev_run = running;
    end
    check_lit("req038_latency_step", rise_at, 20 + S + D + 2);
    check_lit("req038_event_count", rises, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 1);

    // Random keys, bounces and ticks against the model.
    ps = 0; pc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (ps == 0 && $urandom_range(0, 39) == 0) ps = $urandom_range(1, 14);
      if (pc == 0 && $urandom_range(0, 149) == 0) pc = $urandom_range(1, 14);
      step($urandom_range(0, 2) == 0, ps == 0, pc == 0);
      if (ps > 0) ps--;
      if (pc > 0) pc--;
    end
    for (int i = 0; i < 12; i++) step(0, 1, 1);

    // Asynchronous reset at 12:34 while running.
    press_key(0, 10);
    press_key(1, 10);
    ticks(754);
    check_lit("req039_pre_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_lit("req039_async_digits", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    check_lit("req039_async_running", running, 0);
    check_lit("req039_async_rollover", rollover, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 1, 1);
    check_lit("req039_no_spurious_start", running, 0);
    ticks(3);
    check_lit("req039_idle_ignores_tick", sec_ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
